// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, FSM state encoding and instruction-class helpers.
// MDU_MADD_EN enables the multiply-accumulate op codes.
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Classes the hazard unit stalls on: multi-cycle ops and HI/LO moves.
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_MULDIV = 2'd1,
    CLS_MOVE   = 2'd2
  } mdu_class_t;

  function automatic mdu_class_t mdu_op_class(input logic [3:0] op);
    mdu_class_t cls;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: cls = CLS_MULDIV;
      OP_MTHI, OP_MTLO:                   cls = CLS_MOVE;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MULDIV;
`endif
      default:                            cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: products, quotients and accumulate results.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU paths.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             div_zero
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    prod_u;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_r;
  logic [WIDTH-1:0] uns_q;
  logic [WIDTH-1:0] uns_r;
  logic             a_neg;
  logic             b_neg;

  // Sign-extending to 2*WIDTH makes the truncated unsigned product the signed one.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign div_zero = (b == '0);
  assign b_safe   = div_zero ? WIDTH'(1) : b;

  // Signed divide on magnitudes; MIN / -1 falls out as quotient MIN, remainder 0.
  assign a_neg = a[WIDTH-1];
  assign b_neg = b_safe[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b_safe : b_safe;
  assign mag_q = mag_a / mag_b;
  assign mag_r = mag_a % mag_b;
  assign uns_q = a / b_safe;
  assign uns_r = a % b_safe;

  always_comb begin
    next_hi = hi;
    next_lo = lo;
    case (op)
      OP_MULT:  {next_hi, next_lo} = prod_s;
      OP_MULTU: {next_hi, next_lo} = prod_u;
      OP_DIV: begin
        next_lo = (a_neg ^ b_neg) ? -mag_q : mag_q;
        next_hi = a_neg ? -mag_r : mag_r;
      end
      OP_DIVU: begin
        next_lo = uns_q;
        next_hi = uns_r;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {next_hi, next_lo} = {hi, lo} + prod_s;
      OP_MADDU: {next_hi, next_lo} = {hi, lo} + prod_u;
      OP_MSUB:  {next_hi, next_lo} = {hi, lo} - prod_s;
      OP_MSUBU: {next_hi, next_lo} = {hi, lo} - prod_u;
`endif
      default: begin
        next_hi = hi;
        next_lo = lo;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// MDU_MADD_EN (see mdu_pkg/mdu_arith) enables multiply-accumulate ops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; accepts mult/div (to RUN) or mthi/mtlo (direct write)
// ST_RUN  | result pending; counter down to 1, then commit to hi/lo
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] pend_hi, pend_hi_next;
  logic [WIDTH-1:0] pend_lo, pend_lo_next;
  logic             pend_dz, pend_dz_next;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [WIDTH-1:0] arith_hi, arith_lo;
  logic             arith_dz;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op      (op),
    .a       (a),
    .b       (b),
    .hi      (hi),
    .lo      (lo),
    .next_hi (arith_hi),
    .next_lo (arith_lo),
    .div_zero(arith_dz)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      pend_dz <= pend_dz_next;
      hi      <= hi_next;
      lo      <= lo_next;
      busy    <= (state_next == ST_RUN);
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    pend_dz_next = pend_dz;
    hi_next      = hi;
    lo_next      = lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (mdu_op_class(op))
            CLS_MULDIV: begin
              state_next   = ST_RUN;
              cnt_next     = mdu_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              pend_hi_next = arith_hi;
              pend_lo_next = arith_lo;
              pend_dz_next = mdu_is_div(op) && arith_dz;
            end
            CLS_MOVE: begin
              if (op == OP_MTHI) hi_next = a;
              else               lo_next = a;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; the hazard unit never issues it.
        if (cnt <= CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          if (!pend_dz) begin
            hi_next = pend_hi;
            lo_next = pend_lo;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus random ops against a behavioural model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_dz;
  int          remaining;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_is_long(input logic [3:0] o);
    if (o <= 4'd3) return 1'b1;
`ifdef MDU_MADD_EN
    if (o >= 4'd6 && o <= 4'd9) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Reference arithmetic straight from the MIPS definitions, using 64-bit integers.
  task automatic ref_compute(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] h, input logic [31:0] l,
                             output logic [31:0] rh, output logic [31:0] rl, output bit dz);
    int          sx, sy, q, r;
    longint      ps;
    logic [63:0] pu, res;
    sx  = x;
    sy  = y;
    ps  = longint'(sx) * longint'(sy);
    pu  = {32'd0, x} * {32'd0, y};
    res = {h, l};
    dz  = 1'b0;
    case (o)
      4'd0: res = ps;
      4'd1: res = pu;
      4'd2: begin
        if (y == 0) dz = 1'b1;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r, q};
        end
      end
      4'd3: begin
        if (y == 0) dz = 1'b1;
        else res = {x % y, x / y};
      end
      4'd6: res = {h, l} + ps;
      4'd7: res = {h, l} + pu;
      4'd8: res = {h, l} - ps;
      4'd9: res = {h, l} - pu;
      default: ;
    endcase
    rh = res[63:32];
    rl = res[31:0];
  endtask

  task automatic model_edge();
    if (!reset) begin
      remaining = 0;
      m_hi      = '0;
      m_lo      = '0;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0 && !p_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      if (op == 4'd4) m_hi = a;
      else if (op == 4'd5) m_lo = a;
      else if (ref_is_long(op)) begin
        ref_compute(op, a, b, m_hi, m_lo, p_hi, p_lo, p_dz);
        remaining = (op == 4'd2 || op == 4'd3) ? DC : MC;
      end
    end
  endtask

  task automatic step(input logic st, input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic rst);
    start = st;
    op    = o;
    a     = x;
    b     = y;
    reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {63'd0, busy}, {63'd0, remaining > 0});
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
  endtask

  int busy_cnt;

  initial begin
    remaining = 0;
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_dz = 1'b0;
    start = 1'b0; op = '0; a = '0; b = '0; reset = 1'b0;
    #1;

    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("reset_state", {31'd0, busy, hi, lo}, 64'd0);
    idle(1);

    // mult -2 * 3
    step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < MC + 1; i++) begin
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      if (busy) busy_cnt++;
    end
    chk("mult_busy_cycles", 64'(busy_cnt), 64'(MC));
    chk("mult_result", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    step(1'b1, OP_DIVU, 32'd7, 32'd2, 1'b1);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < DC + 1; i++) begin
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      if (busy) busy_cnt++;
    end
    chk("divu_busy_cycles", 64'(busy_cnt), 64'(DC));
    chk("divu_result", {hi, lo}, {32'd1, 32'd3});

    step(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle(DC);
    chk("div_neg_result", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    step(1'b1, OP_MTHI, 32'h11, 32'd0, 1'b1);
    step(1'b1, OP_MTLO, 32'h22, 32'd0, 1'b1);
    step(1'b1, OP_DIV, 32'h1234, 32'd0, 1'b1);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < DC + 1; i++) begin
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      if (busy) busy_cnt++;
    end
    chk("divzero_busy_cycles", 64'(busy_cnt), 64'(DC));
    chk("divzero_keep", {hi, lo}, {32'h11, 32'h22});

    step(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle(DC);
    chk("div_overflow", {hi, lo}, {32'h0, 32'h8000_0000});

    step(1'b1, OP_MTHI, 32'hDEAD, 32'd0, 1'b1);
    chk("mthi", {31'd0, busy, hi}, {32'd0, 32'hDEAD});
    step(1'b1, OP_MTLO, 32'hBEEF, 32'd0, 1'b1);
    chk("mtlo", {31'd0, busy, lo}, {32'd0, 32'hBEEF});
    idle(1);

    // multu issued mid-run must be ignored
    step(1'b1, OP_MULT, 32'd6, 32'd7, 1'b1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    step(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    idle(MC);
    chk("ignored_start", {hi, lo}, {32'd0, 32'd42});

    // reset at busy cycle 3
    step(1'b1, OP_MULT, 32'd9, 32'd9, 1'b1);
    idle(2);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("reset_mid_op", {31'd0, busy, hi, lo}, 64'd0);
    idle(MC + 2);
    chk("no_commit_after_reset", {31'd0, busy, hi, lo}, 64'd0);

    step(1'b1, OP_MTHI, 32'd0, 32'd0, 1'b1);
    step(1'b1, OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b1);
    step(1'b1, OP_MADDU, 32'd1, 32'd1, 1'b1);
`ifdef MDU_MADD_EN
    idle(MC);
    chk("maddu", {hi, lo}, {32'd1, 32'd0});
`else
    chk("maddu_busy", {63'd0, busy}, 64'd0);
    idle(MC);
    chk("maddu_undefined", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra, rb;
      logic        rs, rr;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 9);
        default: ;
      endcase
      rs = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 149) != 0);
      step(rs, 4'($urandom_range(0, 11)), ra, rb, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide unit with HI/LO registers for the 5-stage pipeline, sitting in the E stage beside the ALU. It accepts one operation per start pulse, keeps `busy` high for a fixed, parameter-set latency, then commits the result to HI/LO. The hazard unit stalls the D stage on any MDU instruction while `start` or `busy` is high, and on any mfhi/mflo in that window.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (≥1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk while 0
- start  input  1  E-stage MDU instruction valid this cycle
- op  input  4  operation code, encoding in package
- a  input  WIDTH  forwarded rs value
- b  input  WIDTH  forwarded rt value
- busy  output  1  operation in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- Ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO; MADD, MADDU, MSUB, MSUBU only when the macro is defined.
- FSM states: IDLE, RUN.
- IDLE + start + mult/div class:
  - compute the result from a and b at the start edge into pending_hi/pending_lo;
  - load a countdown with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN:
  - the counter decrements each cycle;
  - on the cycle it reaches 1, commit pending → hi/lo and go to IDLE.
- MTHI/MTLO in IDLE:
  - write a to hi or lo at the start edge;
  - `busy` never rises.
- start in RUN: ignored entirely, with no effect on state, counter, pending, hi or lo. The hazard unit guarantees this does not occur; the bench still checks it.
- Undefined op with start: no effect.
- Arithmetic:
  - mult: signed 2·WIDTH product, hi = upper half, lo = lower half;
  - multu: the same, unsigned;
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend;
  - divu: unsigned quotient and remainder.
- Divide by zero (b==0, div or divu): the operation still runs the full DIV_CYCLES with `busy` high, but hi/lo are left unchanged at commit.
- Signed overflow (div of most-negative by -1): lo = most-negative value, hi = 0.
- Reset value of every output: busy=0, hi=0, lo=0. The FSM returns to IDLE and the counter clears to 0.

## Timing
- start sampled at edge t with a mult/div op: `busy`=1 from after edge t through exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
- New hi/lo visible in the same cycle `busy` falls.
- `busy` is a registered output; it is never combinational from start.
- MTHI/MTLO: hi/lo update visible the cycle after the start edge; zero stall.
- Back-to-back: a start in the first IDLE cycle after commit is accepted. Throughput is one op per N+1 cycles at most.
- Reset mid-operation: at the reset edge, drop the pending result and clear hi/lo and busy. Reset has priority over start.

## Configuration
- MDU_MADD_EN defined:
  - MADD/MADDU/MSUB/MSUBU are accepted;
  - the result is {hi,lo} ± a·b (signed or unsigned product), taking {hi,lo} at the start edge, with 2·WIDTH wrap-around;
  - latency is MULT_CYCLES.
- MDU_MADD_EN undefined: these op codes are treated as undefined (no effect, `busy` stays 0).

## Structure
- Shared package holds:
  - the MDU op code constants;
  - the FSM state encoding;
  - the hazard-unit helper constants for MDU instruction classes.
- One sub-module, `mdu_arith`:
  - purely combinational;
  - takes op, a, b, hi, lo and produces next_hi, next_lo and a divide-by-zero flag;
  - it isolates the signed/unsigned and macro-dependent arithmetic.
- The top handles only the FSM, counter and registers.

## Test plan
- mult a=0xFFFFFFFE (−2), b=3, MULT_CYCLES=5 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; both unchanged while busy.
- divu a=7, b=2 → after 10 busy cycles lo=3, hi=1. Then div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div with b=0 and prior hi=0x11, lo=0x22 → busy high 10 cycles, hi/lo stay 0x11/0x22. Then div 0x80000000 / −1 → lo=0x80000000, hi=0.
- mthi a=0xDEAD, then the next cycle mtlo a=0xBEEF → busy never rises; hi=0xDEAD, lo=0xBEEF one cycle after each.
- Start multu mid-RUN of a mult → ignored, with the first result committed on schedule. Reset driven low at busy cycle 3 → next cycle busy=0, hi=lo=0, no later commit.
- With MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, maddu a=1, b=1 → hi=1, lo=0. Without the macro, the same op leaves hi/lo unchanged and busy=0.
